// File: rtl/mdu_sequencer_if.sv
// Shared RV64M multiply/divide types and the EX <-> MDU handshake bundle.
// The execute stage drives the master side; mdu_sequencer is the slave.

package mdu_pkg;
  typedef logic [63:0] word_t;

  typedef enum logic [3:0] {
    MDU_NOP   = 4'd0,
    MDU_MUL   = 4'd1,
    MDU_MULW  = 4'd2,
    MDU_DIV   = 4'd3,
    MDU_DIVU  = 4'd4,
    MDU_REM   = 4'd5,
    MDU_REMU  = 4'd6,
    MDU_DIVW  = 4'd7,
    MDU_DIVUW = 4'd8,
    MDU_REMW  = 4'd9,
    MDU_REMUW = 4'd10
  } mdu_op_t;
endpackage

interface mdu_if;
  logic            start;
  mdu_pkg::mdu_op_t op;
  mdu_pkg::word_t  srca;
  mdu_pkg::word_t  srcb;
  logic            flush;
  logic            stall;
  logic            done;
  mdu_pkg::word_t  result;

  modport master (output start, op, srca, srcb, flush, input stall, done, result);
  modport slave  (input start, op, srca, srcb, flush, output stall, done, result);
endinterface

// File: rtl/mdu_sequencer.sv
// Iterative RV64M multiply/divide sequencer: radix-2 shift-add multiplier and
// restoring divider, one bit per cycle, sign-corrected and W-extended result.
// Optional build macro MDU_FASTMUL_EN: multiply becomes a single-cycle '*'
// resolved in IDLE and the MUL state / shift-add datapath are removed.

module mdu_sequencer
  import mdu_pkg::*;
(
  input  logic clk,
  input  logic reset,
  mdu_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
`ifndef MDU_FASTMUL_EN
    S_MUL  = 2'd1,
`endif
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  function automatic logic op_is_mul(input mdu_op_t op);
    return (op == MDU_MUL) || (op == MDU_MULW);
  endfunction

  function automatic logic op_is_w(input mdu_op_t op);
    return op inside {MDU_MULW, MDU_DIVW, MDU_DIVUW, MDU_REMW, MDU_REMUW};
  endfunction

  function automatic logic op_is_signed(input mdu_op_t op);
    return op inside {MDU_DIV, MDU_REM, MDU_DIVW, MDU_REMW};
  endfunction

  function automatic logic op_is_rem(input mdu_op_t op);
    return op inside {MDU_REM, MDU_REMU, MDU_REMW, MDU_REMUW};
  endfunction

  function automatic word_t sext32(input logic [31:0] v);
    return {{32{v[31]}}, v};
  endfunction

  state_t     state_r, state_s;
  logic [6:0] cnt_r, cnt_s;
  word_t      a_r, a_s;       // multiplicand, or dividend shifting into quotient
  word_t      b_r, b_s;       // multiplier, or divisor magnitude
  word_t      acc_r, acc_s;   // product accumulator, or partial remainder
  logic       w_r, w_s, rem_r, rem_s, neg_q_r, neg_q_s, neg_r_r, neg_r_s;
  word_t      result_r, result_s;
  logic       done_r, done_s;

  // operand decode used when an instruction is accepted in IDLE
  logic  accept_s, w_in_s, signed_in_s, rem_in_s, sign_a_s, sign_b_s;
  logic  div_zero_s, div_ovf_s;
  word_t a_ext_s, b_ext_s, mag_a_s, mag_b_s, min_s, dvd_s;

  // iteration datapath
  logic [64:0] rsh_s;
  logic        ge_s;
  word_t       rdiv_s, qdiv_s, qsgn_s, rsgn_s, dres_s;
`ifdef MDU_FASTMUL_EN
  word_t       prod_s;
`else
  word_t       mprod_s, mres_s;
`endif

  assign bus.stall  = bus.start && (bus.op != MDU_NOP) && !done_r && !bus.flush;
  assign bus.done   = done_r;
  assign bus.result = result_r;

  // Decode incoming op and form operand magnitudes / special-case flags
  always_comb begin
    accept_s    = bus.start && (bus.op != MDU_NOP);
    w_in_s      = op_is_w(bus.op);
    signed_in_s = op_is_signed(bus.op);
    rem_in_s    = op_is_rem(bus.op);
    a_ext_s     = w_in_s ? (signed_in_s ? sext32(bus.srca[31:0]) : {32'd0, bus.srca[31:0]}) : bus.srca;
    b_ext_s     = w_in_s ? (signed_in_s ? sext32(bus.srcb[31:0]) : {32'd0, bus.srcb[31:0]}) : bus.srcb;
    sign_a_s    = signed_in_s && a_ext_s[63];
    sign_b_s    = signed_in_s && b_ext_s[63];
    mag_a_s     = sign_a_s ? (64'd0 - a_ext_s) : a_ext_s;
    mag_b_s     = sign_b_s ? (64'd0 - b_ext_s) : b_ext_s;
    min_s       = w_in_s ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000;
    div_zero_s  = (b_ext_s == 64'd0);
    div_ovf_s   = signed_in_s && (a_ext_s == min_s) && (b_ext_s == 64'hFFFF_FFFF_FFFF_FFFF);
    dvd_s       = w_in_s ? sext32(bus.srca[31:0]) : bus.srca;
`ifdef MDU_FASTMUL_EN
    prod_s      = bus.srca * bus.srcb;
`endif
  end

  // One restoring-divide / shift-add step plus the final sign/W correction
  always_comb begin
    rsh_s  = {acc_r, a_r[63]};
    ge_s   = (rsh_s >= {1'b0, b_r});
    rdiv_s = ge_s ? (rsh_s[63:0] - b_r) : rsh_s[63:0];
    qdiv_s = {a_r[62:0], ge_s};
    qsgn_s = neg_q_r ? (64'd0 - qdiv_s) : qdiv_s;
    rsgn_s = neg_r_r ? (64'd0 - rdiv_s) : rdiv_s;
    dres_s = rem_r ? rsgn_s : qsgn_s;
    dres_s = w_r ? sext32(dres_s[31:0]) : dres_s;
`ifndef MDU_FASTMUL_EN
    mprod_s = acc_r + (b_r[0] ? a_r : 64'd0);
    mres_s  = w_r ? sext32(mprod_s[31:0]) : mprod_s;
`endif
  end

  // Next-state and datapath-load logic
  always_comb begin
    state_s  = state_r;
    cnt_s    = cnt_r;
    a_s      = a_r;
    b_s      = b_r;
    acc_s    = acc_r;
    w_s      = w_r;
    rem_s    = rem_r;
    neg_q_s  = neg_q_r;
    neg_r_s  = neg_r_r;
    result_s = result_r;
    done_s   = 1'b0;
    if (bus.flush) begin
      state_s = S_IDLE;
      cnt_s   = 7'd0;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (accept_s) begin
            w_s     = w_in_s;
            rem_s   = rem_in_s;
            acc_s   = 64'd0;
            cnt_s   = w_in_s ? 7'd32 : 7'd64;
            neg_q_s = sign_a_s ^ sign_b_s;
            neg_r_s = sign_a_s;
            if (op_is_mul(bus.op)) begin
`ifdef MDU_FASTMUL_EN
              result_s = w_in_s ? sext32(prod_s[31:0]) : prod_s;
              done_s   = 1'b1;
              cnt_s    = 7'd0;
              state_s  = S_DONE;
`else
              a_s     = bus.srca;
              b_s     = bus.srcb;
              state_s = S_MUL;
`endif
            end else if (div_zero_s) begin
              result_s = rem_in_s ? dvd_s : 64'hFFFF_FFFF_FFFF_FFFF;
              done_s   = 1'b1;
              cnt_s    = 7'd0;
              state_s  = S_DONE;
            end else if (div_ovf_s) begin
              result_s = rem_in_s ? 64'd0 : min_s;
              done_s   = 1'b1;
              cnt_s    = 7'd0;
              state_s  = S_DONE;
            end else begin
              // W dividends sit in the upper half so their MSB shifts out first
              a_s     = w_in_s ? {mag_a_s[31:0], 32'd0} : mag_a_s;
              b_s     = mag_b_s;
              state_s = S_DIV;
            end
          end else begin
            state_s = S_IDLE;
          end
        end
`ifndef MDU_FASTMUL_EN
        S_MUL: begin
          acc_s = mprod_s;
          a_s   = {a_r[62:0], 1'b0};
          b_s   = {1'b0, b_r[63:1]};
          cnt_s = cnt_r - 7'd1;
          if (cnt_r == 7'd1) begin
            result_s = mres_s;
            done_s   = 1'b1;
            state_s  = S_DONE;
          end else begin
            state_s = S_MUL;
          end
        end
`endif
        S_DIV: begin
          acc_s = rdiv_s;
          a_s   = qdiv_s;
          cnt_s = cnt_r - 7'd1;
          if (cnt_r == 7'd1) begin
            result_s = dres_s;
            done_s   = 1'b1;
            state_s  = S_DONE;
          end else begin
            state_s = S_DIV;
          end
        end
        S_DONE: begin
          state_s = S_IDLE;
        end
        default: begin
          state_s = S_IDLE;
          cnt_s   = 7'd0;
        end
      endcase
    end
  end

  // State, datapath and registered-output update
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r  <= S_IDLE;
      cnt_r    <= 7'd0;
      a_r      <= 64'd0;
      b_r      <= 64'd0;
      acc_r    <= 64'd0;
      w_r      <= 1'b0;
      rem_r    <= 1'b0;
      neg_q_r  <= 1'b0;
      neg_r_r  <= 1'b0;
      result_r <= 64'd0;
      done_r   <= 1'b0;
    end else begin
      state_r  <= state_s;
      cnt_r    <= cnt_s;
      a_r      <= a_s;
      b_r      <= b_s;
      acc_r    <= acc_s;
      w_r      <= w_s;
      rem_r    <= rem_s;
      neg_q_r  <= neg_q_s;
      neg_r_r  <= neg_r_s;
      result_r <= result_s;
      done_r   <= done_s;
    end
  end

endmodule

// File: doc/mdu_sequencer.md
# mdu_sequencer

Iterative multiply/divide controller for the RV64M ops (`mdu_op_t`) issued from the execute stage. It owns the shift/add multiplier and the restoring-divider datapath and sequences them over multiple cycles. It drives a combinational stall to hold the pipeline and returns a sign-corrected, W-extended 64-bit result with a one-cycle `done` pulse.

## Interface
- Parameters: none (XLEN fixed at 64 via `word_t`).
- `clk`  in  1  system clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-low reset (0 = reset).
- `start`  in  1  EX holds an MDU instruction; held with `op`/`srca`/`srcb` stable until `done`.
- `op`  in  4  `mdu_op_t`; `MDU_NOP` with `start` is ignored.
- `srca`  in  64  rs1 value (dividend / multiplicand).
- `srcb`  in  64  rs2 value (divisor / multiplier).
- `flush`  in  1  synchronous abort of any operation in flight.
- `stall`  out  1  combinational: `start && op!=MDU_NOP && !done && !flush`.
- `done`  out  1  registered one-cycle pulse; `result` is valid.
- `result`  out  64  registered result; holds until the next `done`.

## Operation
- States: IDLE, MUL, DIV, DONE.
- IDLE: on `start && op!=NOP`, latch operands and op, then branch:
  - Special DIV case → DONE.
  - MUL* → MUL.
  - DIV*/REM* → DIV.
- Iteration count N = 64 for full ops and 32 for W ops (`MULW, DIVW, DIVUW, REMW, REMUW`). A 7-bit counter loads N and decrements per cycle. The last iteration (counter==1) → DONE.
- W ops use only `src[31:0]`. For signed W division, operands are taken as 32-bit signed.
- MUL: radix-2 shift-add on raw operands; only the low product bits are kept, so signedness is irrelevant. MULW keeps product[31:0].
- DIV/REM signed: magnitudes are formed at latch time.
  - Restoring divide produces 1 quotient bit per cycle.
  - Quotient sign = sign(a) XOR sign(b); remainder sign = sign(a).
  - Negation is applied when writing `result`.
- Special cases resolve in IDLE with no iterations, result written in the DONE transition:
  - Divisor 0: quotient = all ones; remainder = dividend (W: low 32 bits, sign-extended).
  - Signed overflow (MIN / -1): quotient = MIN; remainder = 0. Applies to 64-bit and to DIVW/REMW with 32-bit MIN.
- W results: `result = {{32{r[31]}}, r[31:0]}`, including DIVUW/REMUW.
- DONE: `done`=1 for exactly this cycle → IDLE. If `start` is still high next cycle, it is a new instruction and is accepted normally (back-to-back).
- `flush` in any state → IDLE next edge. No `done` is produced, `result` is unchanged, and `stall`=0 in the flush cycle. `flush` in IDLE coincident with `start` suppresses acceptance.
- Reset (any time, mid-op included): state IDLE, counter 0, `done`=0, `result`=0. `stall` follows its equation.

## Timing
- Cycle 0 is the IDLE cycle where `start` is accepted; `stall` is high from cycle 0.
- Iterative full op: `done` at cycle 65. Iterative W op: `done` at cycle 33.
- Special-case divide: `done` at cycle 1.
- `stall` falls combinationally in the `done` cycle; the pipeline advances on that edge.
- Minimum spacing between two accepted ops: 1 cycle after `done`.

## Configuration
- `MDU_FASTMUL_EN` defined:
  - MUL/MULW are computed with a single-cycle `*` in IDLE → DONE, with `done` at cycle 1.
  - The MUL state and shift-add datapath are not compiled.
- `MDU_FASTMUL_EN` undefined: iterative multiply as above (cycle 65 / 33).
- Division timing is identical in both builds.

## Test plan
- MUL `srca`=7, `srcb`=-3 → `result`=0xFFFF_FFFF_FFFF_FFEB. `done` at cycle 65, or cycle 1 with `MDU_FASTMUL_EN`; `stall` high cycles 0–64.
- DIV -7/2 → 0xFFFF_FFFF_FFFF_FFFD. REM -7/2 → 0xFFFF_FFFF_FFFF_FFFF. DIVU 100/7 → 14. REMU 100/7 → 2. Each has `done` at cycle 65.
- DIVU 0x1234/0 → 0xFFFF_FFFF_FFFF_FFFF and REMU 0x1234/0 → 0x1234, both with `done` at cycle 1. DIVW 5/0 → all ones.
- DIV 0x8000_0000_0000_0000 / -1 → 0x8000_0000_0000_0000. REM same operands → 0. DIVW 0x8000_0000 / -1 → 0xFFFF_FFFF_8000_0000. All with `done` at cycle 1.
- MULW 0x7FFF_FFFF × 2 → 0xFFFF_FFFF_FFFF_FFFE with `done` at cycle 33. DIVUW 0xFFFF_FFFE / 1 → 0xFFFF_FFFF_FFFF_FFFE.
- Abort and reset:
  - DIV started, `flush` at cycle 10 → no `done`, state IDLE at cycle 11. A new MUL accepted at cycle 11 completes normally.
  - `reset` pulsed low mid-DIV → `result`=0, `done`=0.
  - Back-to-back: two DIVUs with `start` held continuously → second `done` 66 cycles after the first.
